// File: rtl/arm_controller.sv
// -----------------------------------------------------------------------------
// arm_controller
//
// Control unit and run sequencer for the single-cycle ARM-subset datapath.
// Decodes the current instruction into datapath controls and checks its
// condition field against a registered NZCV set. A run/halt FSM gates PC
// advance, and load/store instructions are stretched until data memory
// acknowledges or a timeout expires.
//
// Optional feature macro: PERF_CNT_EN (adds retired_cnt / stall_cnt outputs).
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   level; leaves IDLE, or leaves HALT on a 0->1 edge
//   Instr       in   [31:0] current instruction
//   ALUFlags    in   [3:0] {N,Z,C,V} from the ALU this cycle
//   mem_ready   in   data memory acknowledge, sampled on clk
//   pc_en       out  PC register enable (instruction retires this cycle)
//   RegSrc      out  [1:0] [0]=R15 as RA1, [1]=Rd as RA2
//   RegWrite    out  register file write enable
//   ImmSrc      out  [1:0] 00 imm8 rot, 01 imm12, 10 imm24 branch
//   ALUSrc      out  1 selects extended immediate
//   ALUControl  out  [2:0] 000 ADD,001 SUB,010 AND,011 ORR,100 EOR,101 pass B
//   MemWrite    out  data memory write enable
//   MemtoReg    out  1 selects ReadData as the result
//   PCSrc       out  1 loads Result into PC
//   halted      out  FSM is in HALT
//   err         out  sticky memory timeout flag
//   retired_cnt out  [31:0] pc_en cycles          (PERF_CNT_EN only)
//   stall_cnt   out  [31:0] MEMWAIT cycles         (PERF_CNT_EN only)
//
// Memory handshake: a passing load/store presents its controls (MemWrite for
// a store) and holds them, with Instr held by the stalled PC, until a cycle
// in which mem_ready=1. That cycle is the commit cycle: pc_en=1 and an LDR
// writes its register. The RUN cycle that first presents the access counts
// as the first wait cycle. After MEM_TIMEOUT wait cycles without mem_ready
// the access commits anyway and err is set.
// -----------------------------------------------------------------------------
module arm_controller #(
  parameter logic [31:0] HALT_WORD   = 32'hEAFFFFFE,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [2:0]  ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        halted,
  output logic        err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [3:0]       flags_q;
  logic             start_q;

  // Raw decode of Instr (before condition / FSM gating)
  logic [1:0] d_reg_src;
  logic       d_reg_write;
  logic [1:0] d_imm_src;
  logic       d_alu_src;
  logic [2:0] d_alu_ctrl;
  logic       d_mem_write;
  logic       d_mem_to_reg;
  logic       d_branch;
  logic       d_flag_write;
  logic       d_is_mem;

  logic cond_pass;

  // FSM-gated controls
  logic show;      // present decoded non-write controls
  logic pc_en_c;
  logic rw;
  logic mw;
  logic br;
  logic flag_we;
  logic timeout;
  logic halted_c;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  always_comb begin
    d_reg_src    = 2'b00;
    d_reg_write  = 1'b0;
    d_imm_src    = 2'b00;
    d_alu_src    = 1'b0;
    d_alu_ctrl   = 3'b000;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_branch     = 1'b0;
    d_flag_write = 1'b0;
    d_is_mem     = 1'b0;
    case (Instr[27:26])
      2'b00: begin
        d_alu_src = Instr[25];
        case (Instr[24:21])
          4'b0100: begin d_alu_ctrl = 3'b000; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          4'b0010: begin d_alu_ctrl = 3'b001; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          4'b0000: begin d_alu_ctrl = 3'b010; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          4'b1100: begin d_alu_ctrl = 3'b011; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          4'b0001: begin d_alu_ctrl = 3'b100; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          4'b1101: begin d_alu_ctrl = 3'b101; d_reg_write = 1'b1; d_flag_write = Instr[20]; end
          // CMP: subtract for flags only, S bit is implied
          4'b1010: begin d_alu_ctrl = 3'b001; d_flag_write = 1'b1; end
          default: ; // unsupported opcode retires as a NOP
        endcase
      end
      2'b01: begin
        d_is_mem   = 1'b1;
        d_imm_src  = 2'b01;
        d_alu_src  = ~Instr[25];
        d_alu_ctrl = Instr[23] ? 3'b000 : 3'b001; // U=0 subtracts the offset
        if (Instr[20]) begin
          d_mem_to_reg = 1'b1;
          d_reg_write  = 1'b1;
        end else begin
          d_mem_write = 1'b1;
          d_reg_src   = 2'b10;
        end
      end
      2'b10: begin
        d_reg_src  = 2'b01;
        d_imm_src  = 2'b10;
        d_alu_src  = 1'b1;
        d_alu_ctrl = 3'b000;
        d_branch   = 1'b1;
      end
      default: ; // 11: NOP
    endcase
  end

  // ---------------------------------------------------------------------------
  // Condition check against the registered flags {N,Z,C,V}
  // ---------------------------------------------------------------------------
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    case (Instr[31:28])
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run/halt sequencer: next state and gated controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    show     = 1'b0;
    pc_en_c  = 1'b0;
    rw       = 1'b0;
    mw       = 1'b0;
    br       = 1'b0;
    flag_we  = 1'b0;
    timeout  = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        show = 1'b1;
        if (cond_pass && (Instr == HALT_WORD)) begin
          state_d = S_HALT;
        end else if (cond_pass && d_is_mem && !mem_ready) begin
          // This cycle is the first wait cycle of the access
          state_d = S_MEMWAIT;
          mw      = d_mem_write;
          wait_d  = CNT_W'(1);
        end else begin
          pc_en_c = 1'b1;
          rw      = d_reg_write  & cond_pass;
          mw      = d_mem_write  & cond_pass;
          br      = d_branch     & cond_pass;
          flag_we = d_flag_write & cond_pass;
        end
      end
      S_MEMWAIT: begin
        show = 1'b1;
        mw   = d_mem_write & cond_pass;
        if (mem_ready || (wait_q == WAIT_LAST)) begin
          pc_en_c = 1'b1;
          rw      = d_reg_write & cond_pass;
          timeout = ~mem_ready;
          wait_d  = '0;
          state_d = S_RUN;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
        if (start && !start_q) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // reset forces state_q to IDLE asynchronously, which zeroes every output
  // (MemWrite included) without waiting for a clock edge.
  assign pc_en      = pc_en_c;
  assign RegSrc     = show ? d_reg_src  : 2'b00;
  assign ImmSrc     = show ? d_imm_src  : 2'b00;
  assign ALUSrc     = show & d_alu_src;
  assign ALUControl = show ? d_alu_ctrl : 3'b000;
  assign MemtoReg   = show & d_mem_to_reg;
  assign RegWrite   = rw;
  assign MemWrite   = mw;
  // Writing R15 is a jump
  assign PCSrc      = br | (rw & (Instr[15:12] == 4'hF));
  assign halted     = halted_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      flags_q <= 4'b0000;
      start_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      start_q <= start;
      if (flag_we) flags_q <= ALUFlags;
      if (timeout) err     <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (pc_en_c)               retired_cnt <= retired_cnt + 32'd1;
      if (state_q == S_MEMWAIT)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/arm_controller.md
Name: arm_controller

Overview:
- Control unit and run sequencer for the single-cycle ARM-subset datapath.
- Decodes the current instruction into datapath control signals, evaluates ARM condition codes against a registered NZCV flag set, and gates PC advance through a run/halt FSM.
- Stretches load/store instructions across cycles until data memory acknowledges.
- Its pc_en output drives the datapath PC-enable input.

Parameters:
- HALT_WORD, 32'hEAFFFFFE, instruction encoding (B to self) that halts the core.
- MEM_TIMEOUT, 16, maximum MEMWAIT cycles before the access is forced complete and err is set.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begins execution from IDLE or HALT
- Instr  in  32  current instruction
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- mem_ready  in  1  data memory ack, sampled on clk
- pc_en  out  1  PC register enable
- RegSrc  out  2  [0]=1 selects R15 as RA1; [1]=1 selects Rd as RA2
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 imm8 rotate, 01 imm12, 10 imm24 branch
- ALUSrc  out  1  1 selects extended immediate
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 pass B
- MemWrite  out  1  data memory write enable
- MemtoReg  out  1  1 selects ReadData
- PCSrc  out  1  1 loads Result into PC
- halted  out  1  FSM in HALT
- err  out  1  sticky memory timeout flag

Behaviour:
- Reset (async): state=IDLE, flags NZCV=0000, err=0, timeout counter=0. All outputs 0 while reset is high; MemWrite drops immediately even mid-MEMWAIT.
- Decode is combinational on Instr[27:26]:
  - 00 data-processing: I=Instr[25], cmd=Instr[24:21], S=Instr[20]. ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, MOV 1101 (pass B), CMP 1010 (SUB, RegWrite=0, forces flag update). ALUSrc=I. ImmSrc=00. Unsupported cmd acts as NOP.
  - 01 memory: L=Instr[20]. ALUSrc=~Instr[25]. ImmSrc=01. ALUControl ADD; SUB if U=Instr[23]=0. LDR: MemtoReg=1, RegWrite=1. STR: MemWrite=1, RegSrc[1]=1.
  - 10 branch: RegSrc[0]=1, ImmSrc=10, ALUSrc=1, ADD, PCSrc=1.
  - 11: NOP.
- Condition Instr[31:28]: EQ..LE per ARM using registered flags. 1110 AL always passes; 1111 never passes.
- Condition fail: RegWrite, MemWrite, PCSrc and flag write forced 0. Instruction still retires (pc_en=1).
- Destination Rd=15 with a committed write asserts PCSrc.
- Flags register loads ALUFlags on the commit edge only, when cond passes and (S=1 or CMP).
- FSM:
  - IDLE: pc_en=0, all write enables 0. start=1 -> RUN.
  - RUN: pc_en=1 with decoded controls.
    - Instr==HALT_WORD with cond pass -> HALT; pc_en=0 that cycle; no writes.
    - Passing memory op with mem_ready=0 -> MEMWAIT; pc_en=0, RegWrite=0, MemWrite held asserted.
    - Passing memory op with mem_ready=1 -> commits in one cycle.
  - MEMWAIT: controls held from decode, pc_en=0, RegWrite=0; counter increments each cycle.
    - mem_ready=1 -> commit: pc_en=1, RegWrite per LDR, counter=0 -> RUN.
    - Counter reaches MEM_TIMEOUT-1 without ready -> commit anyway, err=1 (sticky until reset) -> RUN.
  - HALT: halted=1, pc_en=0, writes 0. start rising edge (start=0 previous cycle, 1 now) -> RUN; PC re-executes the halt word unless external logic changes Instr.
- start is ignored in RUN and MEMWAIT.
- Latency: non-memory instruction commits in the same cycle it is presented.

Optional Feature:
- PERF_CNT_EN. When defined:
  - Adds outputs retired_cnt[31:0] and stall_cnt[31:0].
  - retired_cnt increments on every pc_en=1 cycle; stall_cnt increments each MEMWAIT cycle.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: neither port exists; no counter logic is present.

Test Plan:
- Reset, start=1, Instr=E2811005 (ADD R1,R1,#5) -> RUN next cycle; pc_en=1, RegWrite=1, ALUSrc=1, ALUControl=000, ImmSrc=00.
- Instr=E3510000 (CMP R1,#0) with ALUFlags=0100, then Instr=0A000002 (BEQ) -> CMP: RegWrite=0, flags load Z=1; BEQ: PCSrc=1, RegSrc[0]=1, ImmSrc=10.
- Instr=E5912000 (LDR) with mem_ready low 3 cycles -> pc_en=0, RegWrite=0 for 3 cycles; 4th cycle ready: pc_en=1, RegWrite=1, MemtoReg=1.
- STR with mem_ready stuck low -> MemWrite=1 for 16 cycles; err=1 at commit; back to RUN; reset clears err.
- Instr=EAFFFFFE -> halted=1, pc_en=0; start held high stays HALT; start 0->1 -> RUN.
- Assert reset mid-MEMWAIT on STR -> MemWrite=0 immediately, state IDLE, flags 0000. With PERF_CNT_EN, counters read 0.
